model_ddr_writer: RTL and testbench

- Downstream stage of the SD model reader. Consumes its 16-bit word stream (wr_en/wr_data/wr_last) and packs the words into APP_DATA_W-bit beats.
- Buffers the beats in a small FIFO and writes them to DDR through a MIG-style native app interface, starting at a base address.
- Signals completion once the beat carrying the last word has been accepted by the controller.

---
 rtl/model_ddr_writer.sv | 149 ++++++++++++++
 tb/tb_model_ddr_writer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/model_ddr_writer.sv
// model_ddr_writer: packs 16-bit words into app beats, buffers them in a FIFO and writes them over a MIG-style app interface.
// Define MODEL_DDR_WR_BYTESWAP_EN to byte-swap every input word before packing.
module model_ddr_writer #(
  parameter int APP_DATA_W = 128,
  parameter int APP_ADDR_W = 28,
  parameter int ADDR_STEP  = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [APP_ADDR_W-1:0]   base_addr,
  input  logic                    in_en,
  input  logic [15:0]             in_data,
  input  logic                    in_last,
  output logic [APP_ADDR_W-1:0]   app_addr,
  output logic [2:0]              app_cmd,
  output logic                    app_en,
  input  logic                    app_rdy,
  output logic [APP_DATA_W-1:0]   app_wdf_data,
  output logic                    app_wdf_wren,
  output logic                    app_wdf_end,
  output logic [APP_DATA_W/8-1:0] app_wdf_mask,
  input  logic                    app_wdf_rdy,
  output logic                    busy,
  output logic                    done,
  output logic [31:0]             words_written,
  output logic                    overflow
);
  localparam int LANES = APP_DATA_W / 16;
  localparam int MW = APP_DATA_W / 8;
  localparam int LW = LANES > 1 ? $clog2(LANES) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);
  localparam logic [AW:0] ONE = (AW + 1)'(1);
  localparam logic [APP_ADDR_W-1:0] STEP = APP_ADDR_W'(ADDR_STEP);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t r_state, w_next;

  logic [LW-1:0]         r_lane;
  logic [APP_DATA_W-1:0] r_buf, r_beat, w_merged;
  logic [MW-1:0]         r_bmask, w_mask;
  logic                  r_push, r_blast, r_seen_last, r_end, r_cmd_ok, r_dat_ok, r_ovf;
  logic [APP_ADDR_W-1:0] r_addr;
  logic [31:0]           r_words;
  logic [AW:0]           r_wp, r_rp;
  logic [APP_DATA_W-1:0] r_mem_d [FIFO_DEPTH];
  logic [MW-1:0]         r_mem_m [FIFO_DEPTH];
  logic [15:0]           w_word;
  logic                  w_run, w_empty, w_valid, w_acc, w_fin, w_pop, w_full;

`ifdef MODEL_DDR_WR_BYTESWAP_EN
  assign w_word = {in_data[7:0], in_data[15:8]};
`else
  assign w_word = in_data;
`endif

  assign w_run   = r_state == RUN;
  assign w_empty = r_wp == r_rp;
  assign w_valid = w_run & ~w_empty;
  assign w_acc   = w_run & in_en & ~r_seen_last;
  assign w_fin   = w_acc & (r_lane == LAST_LANE | in_last);
  assign w_pop   = w_valid & (r_cmd_ok | app_rdy) & (r_dat_ok | app_wdf_rdy);
  // a pop in the same cycle frees the slot the push needs
  assign w_full  = (r_wp - r_rp) == FULL_CNT && !w_pop;

  always_comb begin
    w_merged = r_buf;
    w_merged[16*r_lane +: 16] = w_word;
    w_mask = '0;
    for (int l = 0; l < LANES; l++) w_mask[2*l +: 2] = {2{l > int'(r_lane)}};
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else r_state <= w_next;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = start ? RUN : IDLE;
      RUN:     w_next = r_end && w_empty ? DONE : RUN;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    busy = r_state == RUN;
    done = r_state == DONE;
    app_en = w_valid & ~r_cmd_ok;
    app_wdf_wren = w_valid & ~r_dat_ok;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lane <= '0; r_buf <= '0; r_beat <= '0; r_bmask <= '0;
      r_push <= 1'b0; r_blast <= 1'b0; r_seen_last <= 1'b0; r_end <= 1'b0;
      r_cmd_ok <= 1'b0; r_dat_ok <= 1'b0; r_ovf <= 1'b0;
      r_addr <= '0; r_words <= '0; r_wp <= '0; r_rp <= '0;
    end else if (r_state == IDLE && start) begin
      r_addr <= base_addr; r_words <= '0; r_ovf <= 1'b0; r_lane <= '0; r_buf <= '0;
      r_push <= 1'b0; r_end <= 1'b0; r_seen_last <= 1'b0;
      r_cmd_ok <= 1'b0; r_dat_ok <= 1'b0; r_wp <= '0; r_rp <= '0;
    end else begin
      r_push <= w_fin;
      r_blast <= w_fin & in_last;
      if (w_fin) begin
        r_beat <= w_merged;
        r_bmask <= w_mask;
      end
      if (w_acc) begin
        r_words <= r_words + 32'd1;
        r_seen_last <= in_last;
        r_lane <= w_fin ? '0 : r_lane + 1'b1;
        r_buf <= w_fin ? '0 : w_merged;
      end
      if (r_push) begin
        if (w_full) r_ovf <= 1'b1;
        else r_wp <= r_wp + ONE;
        if (r_blast) r_end <= 1'b1;
      end
      if (w_pop) begin
        r_rp <= r_rp + ONE;
        r_addr <= r_addr + STEP;
        r_cmd_ok <= 1'b0;
        r_dat_ok <= 1'b0;
      end else begin
        if (app_en & app_rdy) r_cmd_ok <= 1'b1;
        if (app_wdf_wren & app_wdf_rdy) r_dat_ok <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk)
    if (r_push && !w_full) begin
      r_mem_d[r_wp[AW-1:0]] <= r_beat;
      r_mem_m[r_wp[AW-1:0]] <= r_bmask;
    end

  assign app_addr      = r_addr;
  assign app_cmd       = 3'b000;
  assign app_wdf_end   = app_wdf_wren;
  assign app_wdf_data  = w_valid ? r_mem_d[r_rp[AW-1:0]] : '0;
  assign app_wdf_mask  = w_valid ? r_mem_m[r_rp[AW-1:0]] : '0;
  assign words_written = r_words;
  assign overflow      = r_ovf;
endmodule

// File: tb/tb_model_ddr_writer.sv
// tb_model_ddr_writer: randomized bench for model_ddr_writer against a word-list packing model.
module tb_model_ddr_writer;
  logic clk = 0, rst = 1, start = 0, in_en = 0, in_last = 0;
  logic [27:0] base_addr = 0;
  logic [15:0] in_data = 0;
  logic [27:0] app_addr;
  logic [2:0] app_cmd;
  logic app_en, app_rdy = 0, app_wdf_wren, app_wdf_end, app_wdf_rdy = 0, busy, done, overflow;
  logic [127:0] app_wdf_data;
  logic [15:0] app_wdf_mask;
  logic [31:0] words_written;

  model_ddr_writer dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .in_en(in_en), .in_data(in_data), .in_last(in_last),
    .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en), .app_rdy(app_rdy),
    .app_wdf_data(app_wdf_data), .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
    .app_wdf_mask(app_wdf_mask), .app_wdf_rdy(app_wdf_rdy),
    .busy(busy), .done(done), .words_written(words_written), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0, cyc = 0, rdy_pct = 100;
  bit hold_cmd = 0;
  int ndone, done_cyc, pair_cyc, first_en_cyc, en_hi, wren_hi, en_cyc;
  logic [27:0]  oaddr[$];
  logic [127:0] odata[$];
  logic [15:0]  omask[$];
  logic [15:0]  words[$];

`ifdef MODEL_DDR_WR_BYTESWAP_EN
  localparam logic [15:0] SW_EXP = 16'h3412;
`else
  localparam logic [15:0] SW_EXP = 16'h1234;
`endif

  function automatic logic [15:0] sw(input logic [15:0] w);
`ifdef MODEL_DDR_WR_BYTESWAP_EN
    return {w[7:0], w[15:8]};
`else
    return w;
`endif
  endfunction

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  initial forever begin
    @(posedge clk); #1;
    app_rdy = !hold_cmd && ($urandom_range(99) < rdy_pct);
    app_wdf_rdy = $urandom_range(99) < rdy_pct;
  end

  always @(negedge clk) if (!rst) begin
    if (app_en && app_rdy) oaddr.push_back(app_addr);
    if (app_wdf_wren && app_wdf_rdy) begin
      odata.push_back(app_wdf_data);
      omask.push_back(app_wdf_mask);
    end
    if (((app_en && app_rdy) || (app_wdf_wren && app_wdf_rdy)) && oaddr.size() == odata.size()) pair_cyc = cyc;
    if (app_en && first_en_cyc < 0) first_en_cyc = cyc;
    en_hi += int'(app_en);
    wren_hi += int'(app_wdf_wren);
    if (done) begin ndone++; done_cyc = cyc; end
    if (busy) check("wdf_end_cmd", {app_wdf_end, app_cmd}, {app_wdf_wren, 3'b000});
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic clear_mon;
    oaddr.delete(); odata.delete(); omask.delete();
    ndone = 0; pair_cyc = -1; done_cyc = -100; first_en_cyc = -1; en_hi = 0; wren_hi = 0;
  endtask

  task automatic fill(input int n);
    words.delete();
    for (int i = 0; i < n; i++) words.push_back(16'($urandom));
  endtask

  task automatic start_run(input logic [27:0] b);
    base_addr = b; start = 1; tick;
    start = 0; base_addr = 28'($urandom);
  endtask

  task automatic send_words(input int gap_pct, input int extra, input bit with_last);
    for (int i = 0; i < words.size(); i++) begin
      while ($urandom_range(99) < gap_pct) begin
        in_en = 0; start = ($urandom_range(7) == 0); base_addr = 28'($urandom); tick;
      end
      start = 0; in_en = 1; in_data = words[i];
      in_last = with_last && (i == words.size() - 1); en_cyc = cyc; tick;
    end
    for (int i = 0; i < extra; i++) begin
      in_en = 1; in_data = 16'($urandom); in_last = 1'($urandom_range(1)); tick;
    end
    in_en = 0; in_last = 0; start = 0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && ndone == 0; i++) tick;
    check("done_seen", ndone > 0, 1);
    repeat (3) tick;
  endtask

  task automatic verify(input logic [27:0] b, input bit ovf);
    int n, keep;
    n = words.size();
    keep = (n + 7) / 8;
    if (ovf && keep > 16) keep = 16;
    check("ncmd", oaddr.size(), keep);
    check("ndat", odata.size(), keep);
    for (int k = 0; k < keep && k < oaddr.size() && k < odata.size(); k++) begin
      logic [127:0] ed, km;
      logic [15:0] em;
      ed = '0; km = '0; em = 16'hFFFF;
      for (int l = 0; l < 8; l++) if (k * 8 + l < n) begin
        ed[l*16 +: 16] = sw(words[k*8 + l]);
        km[l*16 +: 16] = 16'hFFFF;
        em[2*l +: 2] = 2'b00;
      end
      check("addr", oaddr[k], 28'(b + 28'(k * 8)));
      check("data", odata[k] & km, ed);
      check("mask", omask[k], em);
    end
    check("words", words_written, n);
    check("ovf", overflow, ovf);
    check("ndone", ndone, 1);
    check("done_lag", done_cyc - pair_cyc, 2);
    check("busy_after", busy, 0);
    check("addr_next", app_addr, 28'(b + 28'(keep * 8)));
  endtask

  initial begin
    logic [27:0] b;
    logic [127:0] tmp;
    logic [31:0] wbefore;
    int last_en;
    repeat (2) tick;
    check("rst_ctrl", {app_en, app_wdf_wren, app_wdf_end, busy, done, overflow}, 6'b0);
    check("rst_addr", app_addr, 0);
    check("rst_data", {app_wdf_data, app_wdf_mask}, 0);
    check("rst_words", words_written, 0);
    rst = 0; tick;

    clear_mon; words.delete();
    for (int i = 1; i <= 8; i++) words.push_back(16'(i));
    start_run(28'h100);
    check("busy_run", busy, 1);
    send_words(0, 0, 1);
    last_en = en_cyc;
    wait_done(200);
    check("latency", first_en_cyc - last_en, 2);
    verify(28'h100, 0);

    clear_mon; fill(20); b = 28'($urandom);
    start_run(b); send_words(0, 0, 1); wait_done(200);
    verify(b, 0);
    if (omask.size() > 2) check("mask3", omask[2], 16'hFF00);

    clear_mon; fill(8); hold_cmd = 1;
    start_run(28'h2000); send_words(0, 0, 1);
    for (int i = 0; i < 50 && first_en_cyc < 0; i++) tick;
    repeat (5) tick;
    hold_cmd = 0;
    wait_done(200);
    check("wren_once", wren_hi, 1);
    check("en_held", en_hi >= 5, 1);
    verify(28'h2000, 0);

    clear_mon; fill(136); hold_cmd = 1; b = 28'($urandom);
    start_run(b); send_words(0, 0, 1);
    repeat (10) tick;
    check("ovf_held", overflow, 1);
    hold_cmd = 0;
    wait_done(2000);
    verify(b, 1);

    clear_mon; fill(24); hold_cmd = 1;
    start_run(28'h500); send_words(0, 0, 0);
    repeat (3) tick;
    #3 rst = 1;
    #1;
    check("arst_ctrl", {app_en, app_wdf_wren, busy, done, overflow}, 5'b0);
    check("arst_addr", app_addr, 0);
    check("arst_words", words_written, 0);
    hold_cmd = 0; tick; tick;
    rst = 0;
    repeat (20) tick;
    check("arst_no_done", ndone, 0);
    clear_mon; fill(10);
    start_run(28'h600); send_words(0, 0, 1); wait_done(300);
    verify(28'h600, 0);

    clear_mon; words.delete(); words.push_back(16'h1234);
    start_run(28'h40); send_words(0, 0, 1); wait_done(200);
    verify(28'h40, 0);
    if (odata.size() > 0) begin
      tmp = odata[0];
      check("lane0", tmp[15:0], SW_EXP);
    end

    for (int r = 0; r < 8; r++) begin
      clear_mon;
      fill($urandom_range(60, 1));
      rdy_pct = $urandom_range(100, 40);
      b = (r == 0) ? 28'hFFFFFF0 : 28'($urandom);
      wbefore = words_written;
      in_en = 1; in_data = 16'($urandom); tick; tick; in_en = 0;
      check("idle_ignore", words_written, wbefore);
      start_run(b);
      send_words($urandom_range(40, 0), $urandom_range(3, 0), 1);
      wait_done(4000);
      verify(b, 0);
    end
    rdy_pct = 100;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
